mac_vec_engine: RTL and testbench
=================================

MAC_VEC_ENGINE -- requirements
Module: mac_vec_engine

Interface
REQ-001 SHALL have parameter DW, default 4, meaning unsigned operand width in bits.
REQ-002 SHALL have parameter AW, default 16, meaning accumulator/result width; AW >= 2*DW.
REQ-003 SHALL have parameter LW, default 8, meaning width of the vector-length field.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port start  input  1  begins a job; sampled only in IDLE.
REQ-007 SHALL have port len  input  LW  number of a*b products in the job; captured with start.
REQ-008 SHALL have port in_valid  input  1  operand pair valid.
REQ-009 SHALL have port in_ready  output  1  engine accepts the operand pair this cycle.
REQ-010 SHALL have port a  input  DW  unsigned multiplicand.
REQ-011 SHALL have port b  input  DW  unsigned multiplier.
REQ-012 SHALL have port res_valid  output  1  result is valid and held.
REQ-013 SHALL have port res_ready  input  1  consumer accepts the result.
REQ-014 SHALL have port result  output  AW  final accumulated sum.
REQ-015 SHALL have port ovf  output  1  overflow flag for the current job.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM, DRAIN and DONE.
REQ-018 IDLE->ACCUM SHALL occur on start=1 with len!=0, clearing the accumulator and ovf and loading the remaining-count with len.
REQ-019 IDLE->DONE SHALL occur on start=1 with len=0; the result is 0 and ovf is 0.
REQ-020 in_ready SHALL be 1 only in ACCUM with remaining-count > 0; a beat transfers when in_valid and in_ready are both 1.
REQ-021 Each transfer SHALL decrement the remaining-count and register a*b (2*DW bits, zero-extended to AW) in a product stage.
REQ-022 The accumulate stage SHALL add a valid product to the accumulator one cycle after it is registered.
REQ-023 The transfer of the last beat SHALL move the FSM ACCUM->DRAIN.
REQ-024 DRAIN->DONE SHALL occur once the last product is accumulated, so res_valid rises exactly 2 cycles after the last-beat transfer edge.
REQ-025 In DONE, result and ovf SHALL be held stable while res_valid=1 and res_ready=0.
REQ-026 DONE->IDLE SHALL occur on res_valid and res_ready both 1; start SHALL be ignored in every state except IDLE.
REQ-027 in_valid gaps (bubbles) SHALL stall counting without corrupting the accumulator.
REQ-028 An accumulate carry-out beyond AW bits SHALL set ovf, which stays set until the next job starts.

Reset
REQ-029 rst SHALL force the FSM to IDLE and set accumulator, product stage, remaining-count, result, ovf, res_valid, in_ready and busy to 0, including mid-job.
REQ-030 After rst deasserts, the first accepted start SHALL behave identically to the first start after power-up.

Configuration
REQ-031 With MAC_SAT_EN defined, an accumulate that overflows SHALL clamp the accumulator to all-ones, set ovf, and keep it clamped for the rest of the job.
REQ-032 Without MAC_SAT_EN, the accumulator SHALL wrap modulo 2^AW and ovf SHALL still be set on carry-out.

Structure
REQ-033 A shared package mac_pkg SHALL hold the FSM state typedef (IDLE/ACCUM/DRAIN/DONE) and the default DW/AW/LW constants.
REQ-034 The multiplier SHALL be a separate parametrised combinational sub-module mac_mult (DW x DW -> 2*DW); the product register stays in mac_vec_engine.

Verification
REQ-035 Bench SHALL check: DW=4, AW=16, len=3, pairs (3,5),(15,15),(2,7), no bubbles -> result=254, ovf=0, res_valid 2 cycles after the 3rd transfer.
REQ-036 Bench SHALL check: len=0 start -> DONE with result=0; after res_ready, busy drops next cycle.
REQ-037 Bench SHALL check: len=4, all (15,15), in_valid toggling 1-0-1-0 -> result=900 and exactly 4 transfers counted.
REQ-038 Bench SHALL check: AW=8, len=2, (15,15),(15,15) -> with MAC_SAT_EN result=255 and ovf=1; without it result=194 and ovf=1.
REQ-039 Bench SHALL check: rst pulsed after the 2nd of 4 beats -> all outputs 0 next cycle; a new len=1 job with (4,4) -> result=16.
REQ-040 Bench SHALL check: result held with res_ready=0 for 5 cycles -> result and ovf stable, start pulses ignored, in_ready=0.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared FSM state type and default widths for the MAC vector engine
package mac_pkg;

    localparam int MAC_DW = 4;
    localparam int MAC_AW = 16;
    localparam int MAC_LW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mac_state_t;

endpackage

// File: rtl/mac_mult.sv
// rtl/mac_mult.sv - combinational unsigned DW x DW multiplier
module mac_mult #(
    parameter int DW = 4
) (
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [2*DW-1:0] p
);

    assign p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

endmodule

// File: rtl/mac_vec_engine.sv
// rtl/mac_vec_engine.sv - vector multiply-accumulate engine; MAC_SAT_EN selects saturating accumulate
import mac_pkg::*;

module mac_vec_engine #(
    parameter int DW = MAC_DW,
    parameter int AW = MAC_AW,
    parameter int LW = MAC_LW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [AW-1:0] result,
    output logic          ovf,
    output logic          busy
);

    mac_state_t      state;
    logic [LW-1:0]   rem;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   prod;
    logic            prod_vld;
    logic [2*DW-1:0] mul;
    logic            xfer;
    logic [AW:0]     sum;
    logic            carry;
    logic [AW-1:0]   acc_next;

    mac_mult #(.DW(DW)) u_mult (
        .a (a),
        .b (b),
        .p (mul)
    );

    assign in_ready = (state == ACCUM) && (rem != '0);
    assign busy     = (state != IDLE);
    assign xfer     = in_valid && in_ready;
    assign sum      = {1'b0, acc} + {1'b0, prod};
    assign carry    = sum[AW];

    always_comb begin
        acc_next = sum[AW-1:0];
`ifdef MAC_SAT_EN
        // once clamped, stay pinned at all-ones until the next job clears ovf
        if (carry || ovf) begin
            acc_next = '1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rem       <= '0;
            acc       <= '0;
            prod      <= '0;
            prod_vld  <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            prod_vld <= xfer;
            if (xfer) begin
                prod <= AW'(mul);
            end
            if (prod_vld) begin
                acc <= acc_next;
                if (carry) begin
                    ovf <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        ovf <= 1'b0;
                        if (len == '0) begin
                            result    <= '0;
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            rem   <= len;
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        rem <= rem - 1'b1;
                        if (rem == LW'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // product stage empty means the last product is already in acc
                    if (!prod_vld) begin
                        result    <= acc;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_vec_engine.sv
// tb/tb_mac_vec_engine.sv - self-checking bench for mac_vec_engine against a job-level model
module tb_mac_vec_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  a = '0;
    logic [3:0]  b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] result;
    logic        ovf;
    logic        busy;

    logic        start8 = 1'b0;
    logic [7:0]  len8 = '0;
    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [3:0]  a8 = '0;
    logic [3:0]  b8 = '0;
    logic        res_valid8;
    logic        res_ready8 = 1'b0;
    logic [7:0]  result8;
    logic        ovf8;
    logic        busy8;

    int total = 0;
    int bad = 0;
    int xfer_cnt = 0;

    logic [3:0] va [16];
    logic [3:0] vb [16];

    always #5 clk = ~clk;

    mac_vec_engine #(.DW(4), .AW(16), .LW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .ovf(ovf), .busy(busy)
    );

    mac_vec_engine #(.DW(4), .AW(8), .LW(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .len(len8),
        .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
        .res_valid(res_valid8), .res_ready(res_ready8),
        .result(result8), .ovf(ovf8), .busy(busy8)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // job-level expectation: the true sum, then wrap or clamp into aw bits
    function automatic longint exp_res(input longint s, input int aw);
        longint lim;
        lim = longint'(1) << aw;
`ifdef MAC_SAT_EN
        return (s >= lim) ? lim - 1 : s;
`else
        return s % lim;
`endif
    endfunction

    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) xfer_cnt <= xfer_cnt + 1;
    end

    bit     m_busy = 0, m_active = 0, m_rv = 0, m_ovf = 0;
    int     m_rem = 0, m_wait = 0;
    longint m_sum = 0, m_result = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 0; m_active = 0; m_rv = 0; m_ovf = 0;
            m_rem = 0; m_wait = 0; m_sum = 0;
        end else begin
            chk("busy", busy, m_busy);
            chk("in_ready", in_ready, m_active && m_rem > 0);
            chk("res_valid", res_valid, m_rv);
            if (m_rv) begin
                chk("result", result, m_result);
                chk("ovf", ovf, m_ovf);
            end
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1;
                    m_sum = 0;
                    if (len == 0) begin
                        m_rv = 1; m_result = 0; m_ovf = 0;
                    end else begin
                        m_active = 1; m_rem = len;
                    end
                end
            end else if (m_active) begin
                if (in_valid) begin
                    m_sum += longint'(a) * longint'(b);
                    m_rem--;
                    if (m_rem == 0) begin
                        m_active = 0; m_wait = 2;
                    end
                end
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_rv = 1;
                    m_result = exp_res(m_sum, 16);
                    m_ovf = (m_sum >= 65536);
                end
            end else if (m_rv && res_ready) begin
                m_rv = 0; m_busy = 0;
            end
        end
    end

    // mode: 0 = in_valid always high, 1 = toggle 1-0-1-0, 2 = random bubbles and stray starts
    task automatic run_job(input int L, input int mode, input int hold, input bit pulse,
                           output logic [15:0] r, output logic o, output int lat);
        int  i = 0;
        int  g = 0;
        bit  v = 1;
        bit  rdy;
        start = 1; len = L[7:0];
        @(posedge clk); #1;
        start = 0; len = '0;
        while (i < L && g < 500) begin
            in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? v : 1'($urandom_range(0, 1));
            if (mode == 2) begin
                start = ($urandom_range(0, 3) == 0);
                len = 8'($urandom_range(0, 9));
            end
            a = va[i]; b = vb[i];
            rdy = in_ready;
            @(posedge clk);
            if (rdy && in_valid) i++;
            #1;
            v = !v; g++;
        end
        in_valid = 0; start = 0; len = '0;
        chk("beats_done", i, L);
        lat = 0;
        while (!res_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("res_valid_seen", res_valid, 1);
        r = result; o = ovf;
        for (int k = 0; k < hold; k++) begin
            start = pulse; len = 8'd3; in_valid = pulse; a = 4'd9; b = 4'd9;
            @(posedge clk); #1;
            chk("hold_result", result, r);
            chk("hold_ovf", ovf, o);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_res_valid", res_valid, 1);
        end
        start = 0; in_valid = 0;
        chk("busy_in_done", busy, 1);
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
        chk("busy_after_ack", busy, 0);
    endtask

    logic [15:0] r;
    logic        o;
    int          lat;
    int          x0;
    int          g8;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_ovf", ovf, 0);
        rst = 0;
        @(posedge clk); #1;

        va[0] = 3;  vb[0] = 5;
        va[1] = 15; vb[1] = 15;
        va[2] = 2;  vb[2] = 7;
        run_job(3, 0, 0, 0, r, o, lat);
        chk("basic_result", r, 254);
        chk("basic_ovf", o, 0);
        chk("basic_latency", lat, 2);

        run_job(0, 0, 0, 0, r, o, lat);
        chk("len0_result", r, 0);
        chk("len0_ovf", o, 0);
        chk("len0_latency", lat, 0);

        for (int i = 0; i < 4; i++) begin va[i] = 15; vb[i] = 15; end
        x0 = xfer_cnt;
        run_job(4, 1, 0, 0, r, o, lat);
        chk("bubble_result", r, 900);
        chk("bubble_xfers", xfer_cnt - x0, 4);

        va[0] = 9; vb[0] = 9; va[1] = 1; vb[1] = 1;
        run_job(2, 0, 5, 1, r, o, lat);
        chk("hold_job_result", r, 82);

        start8 = 1; len8 = 8'd2;
        @(posedge clk); #1;
        start8 = 0; in_valid8 = 1; a8 = 15; b8 = 15;
        chk("sat8_ready", in_ready8, 1);
        repeat (2) @(posedge clk);
        #1;
        in_valid8 = 0;
        g8 = 0;
        while (!res_valid8 && g8 < 50) begin @(posedge clk); #1; g8++; end
        chk("sat8_latency", g8, 2);
`ifdef MAC_SAT_EN
        chk("sat8_result", result8, 255);
`else
        chk("sat8_result", result8, 194);
`endif
        chk("sat8_result_model", result8, exp_res(450, 8));
        chk("sat8_ovf", ovf8, 1);
        res_ready8 = 1;
        @(posedge clk); #1;
        res_ready8 = 0;
        chk("sat8_idle", busy8, 0);

        start = 1; len = 8'd4;
        @(posedge clk); #1;
        start = 0; len = '0;
        in_valid = 1; a = 4'd6; b = 4'd7;
        repeat (2) @(posedge clk);
        #1;
        rst = 1; in_valid = 0;
        @(posedge clk); #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_ovf", ovf, 0);
        rst = 0;
        @(posedge clk); #1;
        va[0] = 4; vb[0] = 4;
        run_job(1, 0, 0, 0, r, o, lat);
        chk("post_rst_result", r, 16);
        chk("post_rst_latency", lat, 2);

        for (int j = 0; j < 25; j++) begin
            int L;
            L = $urandom_range(0, 10);
            for (int i = 0; i < 16; i++) begin
                va[i] = 4'($urandom_range(0, 15));
                vb[i] = 4'($urandom_range(0, 15));
            end
            run_job(L, 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)), r, o, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
